// File: rtl/user_bram_ctrl.sv
// user_bram_ctrl
//   Wishbone slave that maps a word-addressed BRAM into a byte address window
//   [BASE, BASE + 4*2^ADDR_W). Each access has a fixed latency of DELAYS
//   cycles from request to ack. The BRAM is enabled for one cycle, DELAYS-1
//   cycles after the request. A request outside the window is acked on the
//   next cycle with zero data and never reaches the BRAM.
//
//   Optional feature, macro BRAM_CTRL_OOR_IRQ_EN:
//     defined   - every out-of-window access sets the sticky irq_o flag,
//                 which is cleared by irq_clr_i
//     undefined - irq_o is tied to 0 and irq_clr_i is ignored
//
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i    wishbone request qualifiers
//   wbs_sel_i/dat_i/adr_i   byte lanes, write data, byte address
//   wbs_ack_o/dat_o         acknowledge, read data (0 outside a read ack)
//   bram_en/we/a/di         BRAM command side
//   bram_do                 BRAM read data, valid the cycle after bram_en
//   irq_clr_i, irq_o        out-of-range interrupt clear and flag
//
// States
//   IDLE | waiting for stb&cyc
//   WAIT | latency count running; bram_en on the last count
//   ACK  | ack cycle of an in-window access
//   ERR  | ack cycle of an out-of-window access
module user_bram_ctrl #(
  parameter int          DELAYS = 10,
  parameter logic [31:0] BASE   = 32'h3800_0000,
  parameter int          ADDR_W = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_a,
  output logic [31:0]       bram_di,
  input  logic [31:0]       bram_do,
  input  logic              irq_clr_i,
  output logic              irq_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  localparam logic [3:0]  EN_CNT = 4'(DELAYS - 1);
  // 33-bit window bounds so a window touching the top of memory cannot wrap
  localparam logic [32:0] WIN_LO = {1'b0, BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_W);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic                we_q, we_d;
  logic                drop_q, drop_d;

  logic req;
  logic in_win;
  logic ack_live;

  assign req    = wbs_stb_i & wbs_cyc_i;
  assign in_win = ({1'b0, wbs_adr_i} >= WIN_LO) && ({1'b0, wbs_adr_i} < WIN_HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (in_win) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
            adr_d   = wbs_adr_i[ADDR_W+1:2];
            dat_d   = wbs_dat_i;
            sel_d   = wbs_sel_i;
            we_d    = wbs_we_i;
            drop_d  = 1'b0;
          end else begin
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == EN_CNT) begin
          // once the BRAM is committed the access completes; a master that
          // has gone away just does not get its ack
          state_d = ACK;
          drop_d  = ~req;
        end else if (!req) begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      drop_q  <= drop_d;
    end
  end

  assign bram_en  = (state_q == WAIT) && (cnt_q == EN_CNT);
  assign bram_we  = bram_en ? ({4{we_q}} & sel_q) : 4'd0;
  assign bram_a   = adr_q;
  assign bram_di  = dat_q;

  assign ack_live  = (state_q == ACK) && !drop_q && req;
  assign wbs_ack_o = ack_live || (state_q == ERR);
  assign wbs_dat_o = (ack_live && !we_q) ? bram_do : 32'd0;

`ifdef BRAM_CTRL_OOR_IRQ_EN
  logic irq_q, irq_d;

  // set has priority over a simultaneous clear
  always_comb begin
    irq_d = (state_q == ERR) | (irq_q & ~irq_clr_i);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_user_bram_ctrl.sv
module tb_user_bram_ctrl;

`ifdef BRAM_CTRL_OOR_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [9:0]  bram_a;
  logic [31:0] bram_di;
  logic [31:0] bram_do;
  logic        irq_clr_i;
  logic        irq_o;

  always #5 wb_clk_i = ~wb_clk_i;

  user_bram_ctrl dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .bram_en  (bram_en),
    .bram_we  (bram_we),
    .bram_a   (bram_a),
    .bram_di  (bram_di),
    .bram_do  (bram_do),
    .irq_clr_i(irq_clr_i),
    .irq_o    (irq_o)
  );

  // BRAM model: byte-write, registered read-first output
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  always @(posedge wb_clk_i) begin
    if (bram_en) begin
      bram_do <= mem[bram_a];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_a][8*b +: 8] <= bram_di[8*b +: 8];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // per-run observations
  int          ack_cnt, ack_first, ack_last, en_cnt, en_first, dat_leak, we_leak;
  logic [31:0] ack_dat, en_di, post_di;
  logic [9:0]  en_a, post_a;
  logic [3:0]  en_we;
  logic        irq_at2;

  // Cycle k=0 is the request cycle. stb/cyc are high for k in [0,drop_at)
  // and [rise_at,rise_end); wb_rst_i is high in cycle rst_at.
  task automatic run(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, input int ncyc, input int drop_at, input int rise_at,
                     input int rise_end, input int rst_at);
    logic hi;
    ack_cnt = 0; ack_first = -1; ack_last = -1; en_cnt = 0; en_first = -1;
    dat_leak = 0; we_leak = 0; ack_dat = '0; en_di = '0; en_a = '0; en_we = '0;
    post_a = '1; post_di = '1; irq_at2 = 1'bx;
    for (int k = 0; k < ncyc; k++) begin
      hi = (k < drop_at) || (k >= rise_at && k < rise_end);
      wbs_stb_i = hi;
      wbs_cyc_i = hi;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      wbs_we_i  = we;
      wb_rst_i  = (k == rst_at);
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        ack_cnt++;
        if (ack_first < 0) ack_first = k;
        ack_last = k;
        ack_dat  = wbs_dat_o;
      end else if (wbs_dat_o != 32'd0) dat_leak++;
      if (bram_en) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
        en_a  = bram_a;
        en_we = bram_we;
        en_di = bram_di;
      end else if (bram_we != 4'd0) we_leak++;
      if (k == 2) irq_at2 = irq_o;
      if (k == rst_at + 1) begin
        post_a  = bram_a;
        post_di = bram_di;
      end
      @(posedge wb_clk_i);
      #1;
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wb_rst_i  = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0; irq_clr_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk_eq("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk_eq("rst_dat", wbs_dat_o, 32'd0);
    chk_eq("rst_en", {31'd0, bram_en}, 32'd0);
    chk_eq("rst_we", {28'd0, bram_we}, 32'd0);
    chk_eq("rst_a", {22'd0, bram_a}, 32'd0);
    chk_eq("rst_di", bram_di, 32'd0);
    chk_eq("rst_irq", {31'd0, irq_o}, 32'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;

    // full write
    run(32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 14, 11, 99, 99, 99);
    chk_eq("wr_en_cyc", en_first, 32'd9);
    chk_eq("wr_en_cnt", en_cnt, 32'd1);
    chk_eq("wr_a", {22'd0, en_a}, 32'd4);
    chk_eq("wr_we", {28'd0, en_we}, 32'hF);
    chk_eq("wr_di", en_di, 32'hDEAD_BEEF);
    chk_eq("wr_ack_cyc", ack_first, 32'd10);
    chk_eq("wr_ack_cnt", ack_cnt, 32'd1);
    chk_eq("wr_dat_o", ack_dat, 32'd0);
    chk_eq("wr_we_leak", we_leak, 32'd0);

    // read back
    run(32'h3800_0010, 32'd0, 4'hF, 1'b0, 14, 11, 99, 99, 99);
    chk_eq("rd_ack_cyc", ack_first, 32'd10);
    chk_eq("rd_dat", ack_dat, 32'hDEAD_BEEF);
    chk_eq("rd_we", {28'd0, en_we}, 32'd0);
    chk_eq("rd_dat_leak", dat_leak, 32'd0);

    // partial write of the low half, then read
    run(32'h3800_0010, 32'h0000_1234, 4'h3, 1'b1, 14, 11, 99, 99, 99);
    chk_eq("pw_we", {28'd0, en_we}, 32'h3);
    run(32'h3800_0010, 32'd0, 4'hF, 1'b0, 14, 11, 99, 99, 99);
    chk_eq("pw_rd", ack_dat, 32'hDEAD_1234);

    // out of window
    run(32'h3000_0000, 32'h1111_1111, 4'hF, 1'b1, 4, 1, 99, 99, 99);
    chk_eq("oor_ack_cyc", ack_first, 32'd1);
    chk_eq("oor_ack_cnt", ack_cnt, 32'd1);
    chk_eq("oor_dat", ack_dat, 32'd0);
    chk_eq("oor_en_cnt", en_cnt, 32'd0);
    chk_eq("oor_irq_t2", {31'd0, irq_at2}, {31'd0, IRQ_EN});
    @(negedge wb_clk_i);
    chk_eq("oor_irq_held", {31'd0, irq_o}, {31'd0, IRQ_EN});
    @(posedge wb_clk_i); #1;
    irq_clr_i = 1'b1;
    @(posedge wb_clk_i); #1;
    irq_clr_i = 1'b0;
    @(negedge wb_clk_i);
    chk_eq("oor_irq_clr", {31'd0, irq_o}, 32'd0);
    @(posedge wb_clk_i); #1;

    // window upper boundary: last word is in, next byte past it is out
    run(32'h3800_0FFC, 32'hA5A5_5A5A, 4'hF, 1'b1, 14, 11, 99, 99, 99);
    chk_eq("top_a", {22'd0, en_a}, 32'h3FF);
    chk_eq("top_ack_cyc", ack_first, 32'd10);
    run(32'h3800_1000, 32'd0, 4'hF, 1'b0, 4, 1, 99, 99, 99);
    chk_eq("past_ack_cyc", ack_first, 32'd1);
    chk_eq("past_en_cnt", en_cnt, 32'd0);

    // abort at T+5, new request at T+7
    run(32'h3800_0010, 32'd0, 4'hF, 1'b0, 20, 5, 7, 18, 99);
    chk_eq("ab_en_cyc", en_first, 32'd16);
    chk_eq("ab_en_cnt", en_cnt, 32'd1);
    chk_eq("ab_ack_cyc", ack_first, 32'd17);
    chk_eq("ab_ack_cnt", ack_cnt, 32'd1);
    chk_eq("ab_dat", ack_dat, 32'hDEAD_1234);

    // stb dropped on the bram_en cycle: access completes, no ack
    run(32'h3800_0010, 32'd0, 4'hF, 1'b0, 14, 9, 99, 99, 99);
    chk_eq("late_en_cnt", en_cnt, 32'd1);
    chk_eq("late_ack_cnt", ack_cnt, 32'd0);

    // back-to-back reads
    run(32'h3800_0010, 32'd0, 4'hF, 1'b0, 25, 22, 99, 99, 99);
    chk_eq("b2b_ack1", ack_first, 32'd10);
    chk_eq("b2b_ack2", ack_last, 32'd21);
    chk_eq("b2b_ack_cnt", ack_cnt, 32'd2);
    chk_eq("b2b_en_cnt", en_cnt, 32'd2);

    // reset mid-write
    run(32'h3800_0020, 32'h1234_5678, 4'hF, 1'b1, 14, 5, 99, 99, 4);
    chk_eq("rs_en_cnt", en_cnt, 32'd0);
    chk_eq("rs_ack_cnt", ack_cnt, 32'd0);
    chk_eq("rs_a", {22'd0, post_a}, 32'd0);
    chk_eq("rs_di", post_di, 32'd0);
    chk_eq("rs_mem", mem[8], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
